// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake, optional skid slot,
// flush-to-bubble and a saturating stall counter.
module ex_mem_stage_reg #(
    parameter int M_W    = 3,
    parameter int WB_W   = 3,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M_W-1:0]    M,
    input  logic [WB_W-1:0]   WB,
    input  logic [DATA_W-1:0] Add_result,
    input  logic              zero,
    input  logic [DATA_W-1:0] Alu_result,
    input  logic [DATA_W-1:0] Dato2,
    input  logic [REG_W-1:0]  Direccion,
    input  logic [DATA_W-1:0] jump_address,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M_W-1:0]    M_out,
    output logic [WB_W-1:0]   WB_out,
    output logic [DATA_W-1:0] Add_result_out,
    output logic              zero_out,
    output logic [DATA_W-1:0] Alu_result_out,
    output logic [DATA_W-1:0] Dato2_out,
    output logic [REG_W-1:0]  Direccion_out,
    output logic [DATA_W-1:0] jump_address_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BUS_W = M_W + WB_W + 4*DATA_W + 1 + REG_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_BOTH  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nstate;
    logic [BUS_W-1:0]   r_main;
    logic [BUS_W-1:0]   r_skid;
    logic [CNT_W-1:0]   r_stall;
    logic [BUS_W-1:0]   w_in_bus;
    logic [M_W-1:0]     w_m;
    logic [WB_W-1:0]    w_wb;
    logic               w_xin;
    logic               w_xout;
    logic               w_ld_main_in;
    logic               w_ld_main_skid;
    logic               w_ld_skid;

    assign w_in_bus = {M, WB, Add_result, zero, Alu_result, Dato2, Direccion, jump_address};
    assign {w_m, w_wb, Add_result_out, zero_out, Alu_result_out, Dato2_out,
            Direccion_out, jump_address_out} = r_main;

    assign out_valid = (r_state != ST_EMPTY);
    // Control groups are forced to a NOP whenever the slot holds no valid bundle.
    assign M_out     = out_valid ? w_m  : '0;
    assign WB_out    = out_valid ? w_wb : '0;
    assign stall_cnt = r_stall;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (r_state != ST_BOTH);
        end else begin : g_noskid
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    assign w_xin  = in_valid & in_ready;
    assign w_xout = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate       = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_nstate = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_ld_main_in = 1'b1;
                        w_nstate     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_xin && w_xout) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_xout) begin
                        w_nstate = ST_EMPTY;
                    end else if (w_xin && (SKID != 0)) begin
                        // Main is blocked downstream: park the new bundle behind it.
                        w_ld_skid = 1'b1;
                        w_nstate  = ST_BOTH;
                    end
                end
                ST_BOTH: begin
                    if (out_ready) begin
                        w_ld_main_skid = 1'b1;
                        w_nstate       = ST_FULL;
                    end
                end
                default: w_nstate = ST_EMPTY;
            endcase
        end
    end

    // Data fields are left untouched by flush; only the valid state is killed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
        end else if (w_ld_main_in) begin
            r_main <= w_in_bus;
        end else if (w_ld_main_skid) begin
            r_main <= r_skid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid <= '0;
        end else if (w_ld_skid) begin
            r_skid <= w_in_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (out_valid && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + CNT_ONE;
        end
    end

endmodule
